phase_freq_est: RTL and testbench



---
 rtl/phase_freq_est_if.sv | 25 ++
 rtl/phase_freq_est.sv | 141 ++++++++++++++
 tb/tb_phase_freq_est.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/phase_freq_est_if.sv
// Phase-sample / frequency-result bus of the phase_freq_est frequency estimator.
// The master drives the phase samples, the clear request and freq_ready.
// The slave (the estimator) returns the averaged tuning word, overrun and locked.
interface phase_freq_est_if #(
  parameter int ACC_SIZE = 28
);
  logic                clear;
  logic [ACC_SIZE-1:0] phase_in;
  logic                phase_valid;
  logic [ACC_SIZE-1:0] freq_word;
  logic                freq_valid;
  logic                freq_ready;
  logic                overrun;
  logic                locked;

  modport master (
    output clear, phase_in, phase_valid, freq_ready,
    input  freq_word, freq_valid, overrun, locked
  );

  modport slave (
    input  clear, phase_in, phase_valid, freq_ready,
    output freq_word, freq_valid, overrun, locked
  );
endinterface

// File: rtl/phase_freq_est.sv
// phase_freq_est: recovers a DDS tuning word from a stream of phase samples.
// Consecutive samples are differenced modulo 2^ACC_SIZE, and 2^AVG_LOG2 deltas
// are summed. Each full window yields floor(sum / 2^AVG_LOG2) on a valid/ready
// output with a sticky overrun flag.
// Optional macro LOCK_DETECT_EN adds a delta-stability detector driving 'locked'.
// Without that macro, 'locked' is tied low.
module phase_freq_est #(
  parameter int ACC_SIZE   = 28,
  parameter int AVG_LOG2   = 4,
  parameter int LOCK_TOL   = 0,
  parameter int LOCK_COUNT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  phase_freq_est_if.slave    bus
);

  localparam int SUM_W = ACC_SIZE + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]          r_state;
  logic [ACC_SIZE-1:0] r_prev_phase;
  logic [SUM_W-1:0]    r_sum;
  logic [CNT_W-1:0]    r_cnt;
  logic [ACC_SIZE-1:0] r_freq_word;
  logic                r_freq_valid;
  logic                r_overrun;

  logic [ACC_SIZE-1:0] w_delta;
  logic [SUM_W-1:0]    w_sum_next;
  logic [SUM_W-1:0]    w_sum_shifted;
  logic [ACC_SIZE-1:0] w_result;
  logic                w_accept;
  logic                w_last;

  // Unsigned subtraction truncated to ACC_SIZE makes phase wrap-around transparent
  assign w_delta       = bus.phase_in - r_prev_phase;
  assign w_sum_next    = r_sum + SUM_W'(w_delta);
  assign w_sum_shifted = w_sum_next >> AVG_LOG2;
  assign w_result      = w_sum_shifted[ACC_SIZE-1:0];
  assign w_accept      = bus.phase_valid && (r_state == S_RUN);
  assign w_last        = w_accept && (r_cnt == CNT_LAST);

  assign bus.freq_word  = r_freq_word;
  assign bus.freq_valid = r_freq_valid;
  assign bus.overrun    = r_overrun;

  // Priming, window accumulation and result handshake; clear wins over any sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_prev_phase <= '0;
      r_sum        <= '0;
      r_cnt        <= '0;
      r_freq_word  <= '0;
      r_freq_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (bus.clear) begin
      r_state      <= S_EMPTY;
      r_sum        <= '0;
      r_cnt        <= '0;
      r_freq_word  <= '0;
      r_freq_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (bus.phase_valid) begin
        r_prev_phase <= bus.phase_in;
        r_state      <= S_RUN;
      end
      if (w_accept) begin
        if (w_last) begin
          r_sum <= '0;
          r_cnt <= '0;
        end else begin
          r_sum <= w_sum_next;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (w_last) begin
        r_freq_word  <= w_result;
        r_freq_valid <= 1'b1;
        if (r_freq_valid && !bus.freq_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (r_freq_valid && bus.freq_ready) begin
        r_freq_valid <= 1'b0;
      end
    end
  end

`ifdef LOCK_DETECT_EN
  localparam int STABLE_W = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(LOCK_COUNT);

  logic [ACC_SIZE-1:0] r_prev_delta;
  logic                r_delta_seeded;
  logic [STABLE_W-1:0] r_stable_cnt;
  logic [ACC_SIZE-1:0] w_diff;
  logic [ACC_SIZE-1:0] w_abs_diff;

  // Two's-complement magnitude stays exact as an unsigned value, even for the most negative diff
  assign w_diff     = w_delta - r_prev_delta;
  assign w_abs_diff = w_diff[ACC_SIZE-1] ? (~w_diff + ACC_SIZE'(1)) : w_diff;
  assign bus.locked = (r_stable_cnt == STABLE_MAX);

  // The first delta after priming only seeds the reference; later deltas grow or reset the run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_delta   <= '0;
      r_delta_seeded <= 1'b0;
      r_stable_cnt   <= '0;
    end else if (bus.clear || (bus.phase_valid && (r_state == S_EMPTY))) begin
      r_prev_delta   <= '0;
      r_delta_seeded <= 1'b0;
      r_stable_cnt   <= '0;
    end else if (w_accept) begin
      r_prev_delta   <= w_delta;
      r_delta_seeded <= 1'b1;
      if (r_delta_seeded) begin
        if (w_abs_diff <= ACC_SIZE'(LOCK_TOL)) begin
          if (r_stable_cnt != STABLE_MAX) begin
            r_stable_cnt <= r_stable_cnt + STABLE_W'(1);
          end
        end else begin
          r_stable_cnt <= '0;
        end
      end
    end
  end
`else
  logic w_unused_lock_cfg;

  assign w_unused_lock_cfg = (LOCK_TOL == 0) ^ (LOCK_COUNT == 0);
  assign bus.locked        = 1'b0;
`endif

endmodule

// File: tb/tb_phase_freq_est.sv
// Directed testbench for phase_freq_est.
// It uses hand-computed expected tuning words, handshake/overrun cases, an
// asynchronous mid-window reset and a lock/gap sequence.
module tb_phase_freq_est;

   localparam int ACC_SIZE = 28;
   localparam int AVG_LOG2 = 4;
   localparam int N        = 1 << AVG_LOG2;

`ifdef LOCK_DETECT_EN
   localparam logic LOCK_ON = 1'b1;
`else
   localparam logic LOCK_ON = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rstN;
   logic [ACC_SIZE-1:0] phase;
   int                  compareCount = 0;
   int                  mismatchCount = 0;

   phase_freq_est_if #(.ACC_SIZE(ACC_SIZE)) bus ();

   phase_freq_est #(
      .ACC_SIZE  (ACC_SIZE),
      .AVG_LOG2  (AVG_LOG2),
      .LOCK_TOL  (0),
      .LOCK_COUNT(8)
   ) dut (
      .clk  (clk),
      .rst_n(rstN),
      .bus  (bus)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Counts every comparison and reports each mismatch on one line
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of phase input and leaves the bench 1 ns after the edge
   task automatic applyStimulus(input logic [ACC_SIZE-1:0] ph, input logic valid);
      bus.phase_in    = ph;
      bus.phase_valid = valid;
      @(posedge clk);
      #1;
      bus.phase_valid = 1'b0;
   endtask

   task automatic stepPhase(input logic [ACC_SIZE-1:0] delta);
      phase = phase + delta;
      applyStimulus(phase, 1'b1);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(phase, 1'b0);
   endtask

   task automatic clearBlock();
      bus.clear       = 1'b1;
      bus.phase_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.clear       = 1'b0;
      bus.phase_valid = 1'b0;
   endtask

   // Main directed sequence
   initial begin
      rstN            = 1'b0;
      bus.clear       = 1'b0;
      bus.phase_in    = '0;
      bus.phase_valid = 1'b0;
      bus.freq_ready  = 1'b1;
      phase           = '0;
      #12;
      checkOutput("rst_word",    64'(bus.freq_word), 64'h0);
      checkOutput("rst_valid",   64'(bus.freq_valid), 64'h0);
      checkOutput("rst_overrun", 64'(bus.overrun), 64'h0);
      checkOutput("rst_locked",  64'(bus.locked), 64'h0);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] steady step 0x0100000");
      phase = '0;
      applyStimulus(phase, 1'b1);
      for (int k = 1; k < N; k++) stepPhase(28'h0100000);
      checkOutput("t1_before_last", 64'(bus.freq_valid), 64'h0);
      stepPhase(28'h0100000);
      checkOutput("t1_valid", 64'(bus.freq_valid), 64'h1);
      checkOutput("t1_word",  64'(bus.freq_word), 64'h0100000);
      idleCycles(1);
      checkOutput("t1_consumed", 64'(bus.freq_valid), 64'h0);

      $display("[TB] wrap-around step 0x20");
      clearBlock();
      phase = 28'hFFFFFF0;
      applyStimulus(phase, 1'b1);
      for (int k = 0; k < N; k++) stepPhase(28'h20);
      checkOutput("t2_valid", 64'(bus.freq_valid), 64'h1);
      checkOutput("t2_word",  64'(bus.freq_word), 64'h20);
      idleCycles(1);

      $display("[TB] alternating 0x10/0x11");
      clearBlock();
      phase = '0;
      applyStimulus(phase, 1'b1);
      for (int k = 0; k < N; k++) stepPhase((k % 2 == 1) ? 28'h11 : 28'h10);
      checkOutput("t3_word", 64'(bus.freq_word), 64'h10);
      idleCycles(1);

      $display("[TB] handshake and overrun");
      bus.freq_ready = 1'b0;
      clearBlock();
      phase = '0;
      applyStimulus(phase, 1'b1);
      for (int k = 0; k < N; k++) stepPhase(28'h100);
      checkOutput("t4_first_valid", 64'(bus.freq_valid), 64'h1);
      checkOutput("t4_first_word",  64'(bus.freq_word), 64'h100);
      for (int k = 0; k < N - 1; k++) stepPhase(28'h300);
      checkOutput("t4_word_held",  64'(bus.freq_word), 64'h100);
      checkOutput("t4_valid_held", 64'(bus.freq_valid), 64'h1);
      bus.freq_ready = 1'b1;
      stepPhase(28'h300);
      bus.freq_ready = 1'b0;
      checkOutput("t4_samedge_valid",   64'(bus.freq_valid), 64'h1);
      checkOutput("t4_samedge_word",    64'(bus.freq_word), 64'h300);
      checkOutput("t4_samedge_overrun", 64'(bus.overrun), 64'h0);
      for (int k = 0; k < N; k++) stepPhase(28'h200);
      checkOutput("t4_ovr_word",    64'(bus.freq_word), 64'h200);
      checkOutput("t4_ovr_flag",    64'(bus.overrun), 64'h1);
      checkOutput("t4_ovr_valid",   64'(bus.freq_valid), 64'h1);
      bus.freq_ready = 1'b1;
      idleCycles(1);
      bus.freq_ready = 1'b0;
      checkOutput("t4_drain_valid",   64'(bus.freq_valid), 64'h0);
      checkOutput("t4_sticky_overrun", 64'(bus.overrun), 64'h1);
      clearBlock();
      checkOutput("t4_clear_overrun", 64'(bus.overrun), 64'h0);
      checkOutput("t4_clear_word",    64'(bus.freq_word), 64'h0);

      $display("[TB] asynchronous reset mid-window");
      phase = '0;
      applyStimulus(phase, 1'b1);
      for (int k = 0; k < N; k++) stepPhase(28'h80);
      checkOutput("t5_pre_word", 64'(bus.freq_word), 64'h80);
      for (int k = 0; k < 5; k++) stepPhase(28'h80);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("t5_async_valid",   64'(bus.freq_valid), 64'h0);
      checkOutput("t5_async_word",    64'(bus.freq_word), 64'h0);
      checkOutput("t5_async_overrun", 64'(bus.overrun), 64'h0);
      @(posedge clk);
      #2;
      rstN = 1'b1;
      @(posedge clk);
      #1;
      bus.freq_ready = 1'b1;
      phase = 28'h1234567;
      applyStimulus(phase, 1'b1);
      for (int k = 0; k < N - 1; k++) stepPhase(28'h30);
      checkOutput("t5_after_n", 64'(bus.freq_valid), 64'h0);
      stepPhase(28'h30);
      checkOutput("t5_after_n1_valid", 64'(bus.freq_valid), 64'h1);
      checkOutput("t5_after_n1_word",  64'(bus.freq_word), 64'h30);
      idleCycles(1);

      $display("[TB] lock sequence with gaps");
      clearBlock();
      phase = '0;
      applyStimulus(phase, 1'b1);
      for (int k = 0; k < 8; k++) stepPhase(28'h40);
      checkOutput("t6_lock_8th", 64'(bus.locked), 64'h0);
      stepPhase(28'h40);
      checkOutput("t6_lock_9th", 64'(bus.locked), 64'(LOCK_ON));
      for (int k = 0; k < 3; k++) begin
         idleCycles(3);
         stepPhase(28'h40);
      end
      checkOutput("t6_lock_gaps", 64'(bus.locked), 64'(LOCK_ON));
      stepPhase(28'h45);
      checkOutput("t6_lock_drop", 64'(bus.locked), 64'h0);
      stepPhase(28'h40);
      idleCycles(3);
      stepPhase(28'h40);
      checkOutput("t6_before_last", 64'(bus.freq_valid), 64'h0);
      stepPhase(28'h40);
      checkOutput("t6_valid", 64'(bus.freq_valid), 64'h1);
      checkOutput("t6_word",  64'(bus.freq_word), 64'h40);
      idleCycles(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
